// File: rtl/stream_mux_rr_pkg.sv
// ---------------------------------------------------------------------------
// stream_mux_pkg
//   Shared types and helpers for the round-robin / fixed-priority stream mux.
//   - prio_mode_e  : arbitration policy selector (round-robin or fixed).
//   - lock_state_e : packet-lock state of the mux.
//   - chan_idx_w() : width of a channel index for a given channel count.
// ---------------------------------------------------------------------------
package stream_mux_pkg;

    typedef enum logic {
        PRIO_RR    = 1'b0,
        PRIO_FIXED = 1'b1
    } prio_mode_e;

    typedef enum logic {
        LOCK_IDLE = 1'b0,
        LOCK_HELD = 1'b1
    } lock_state_e;

    // Index width for n channels; a single channel still needs one bit so
    // that the select vectors never collapse to zero width.
    function automatic int chan_idx_w(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/stream_mux_rr_if.sv
// ---------------------------------------------------------------------------
// stream_mux_rr_if
//   Bundles the N input streams and the single output stream of the mux.
//   Ports (signals):
//     in_valid  [N_CH]     per-channel valid
//     in_data   [N_CH*W]   channel i in bits [i*W +: W]
//     in_last   [N_CH]     per-channel end-of-packet
//     in_ready  [N_CH]     per-channel ready (driven by the mux)
//     out_valid/out_data/out_last/out_sel   registered output beat
//     out_ready             downstream ready
//   Modports:
//     slave  : the mux itself (consumes the inputs, drives the output stream)
//     master : the environment (sources and the downstream sink)
// ---------------------------------------------------------------------------
interface stream_mux_rr_if
    import stream_mux_pkg::*;
#(
    parameter int N_CH = 4,
    parameter int W    = 4
);
    localparam int SW = chan_idx_w(N_CH);

    logic [N_CH-1:0]   in_valid;
    logic [N_CH*W-1:0] in_data;
    logic [N_CH-1:0]   in_last;
    logic [N_CH-1:0]   in_ready;
    logic              out_valid;
    logic [W-1:0]      out_data;
    logic              out_last;
    logic [SW-1:0]     out_sel;
    logic              out_ready;

    modport slave (
        input  in_valid, in_data, in_last, out_ready,
        output in_ready, out_valid, out_data, out_last, out_sel
    );

    modport master (
        output in_valid, in_data, in_last, out_ready,
        input  in_ready, out_valid, out_data, out_last, out_sel
    );

endinterface

// File: rtl/stream_mux_rr_arbiter.sv
// ---------------------------------------------------------------------------
// rr_arbiter
//   Purely combinational request arbiter.
//   Ports:
//     req         [N_CH]  request vector (one bit per channel)
//     ptr         [SW]    round-robin start channel (ignored in fixed mode)
//     grant       [SW]    index of the winning channel
//     grant_valid         at least one request is present
//   The search starts at ptr and walks upward with wrap. Fixed priority is
//   the same search with the start forced to channel 0.
// ---------------------------------------------------------------------------
module rr_arbiter
    import stream_mux_pkg::*;
#(
    parameter int N_CH      = 4,
    parameter int PRIO_MODE = 0,
    localparam int SW       = chan_idx_w(N_CH)
) (
    input  logic [N_CH-1:0] req,
    input  logic [SW-1:0]   ptr,
    output logic [SW-1:0]   grant,
    output logic            grant_valid
);

    logic [SW-1:0]   base;
    logic [SW-1:0]   rot_idx [N_CH];
    logic [N_CH-1:0] rot_req;
    logic [N_CH-1:0] first;

    assign base        = (PRIO_MODE == int'(PRIO_FIXED)) ? '0 : ptr;
    assign grant_valid = |req;

    genvar gi;
    generate
        for (gi = 0; gi < N_CH; gi++) begin : g_rot
            // One spare bit so base+gi cannot overflow before the wrap
            // compare; N_CH need not be a power of two.
            logic [SW:0] sum;
            assign sum         = {1'b0, base} + (SW+1)'(gi);
            assign rot_idx[gi] = (sum >= (SW+1)'(N_CH)) ? SW'(sum - (SW+1)'(N_CH))
                                                        : SW'(sum);
            assign rot_req[gi] = req[rot_idx[gi]];

            // Position gi wins only if no position closer to base requests.
            if (gi == 0) begin : g_first0
                assign first[gi] = rot_req[gi];
            end else begin : g_firstn
                assign first[gi] = rot_req[gi] & ~(|rot_req[gi-1:0]);
            end
        end

        // first is one-hot (or zero), so the winning index is the OR of the
        // masked rotated indices, built one grant bit at a time.
        for (gi = 0; gi < SW; gi++) begin : g_gbit
            logic [N_CH-1:0] col;
            genvar gj;
            for (gj = 0; gj < N_CH; gj++) begin : g_col
                assign col[gj] = rot_idx[gj][gi];
            end
            assign grant[gi] = |(first & col);
        end
    endgenerate

endmodule

// File: rtl/stream_mux_rr.sv
// ---------------------------------------------------------------------------
// stream_mux_rr
//   N:1 packet-aware streaming multiplexer with a registered output stage.
//   Ports:
//     clk    rising-edge clock
//     rst_n  synchronous active-low reset
//     bus    stream_mux_rr_if.slave (all input channels + output stream)
//   Once a channel wins with a non-last beat, the mux locks onto it until
//   its last beat is taken. The round-robin pointer advances past a channel
//   only when that channel finishes a packet.
// ---------------------------------------------------------------------------
module stream_mux_rr
    import stream_mux_pkg::*;
#(
    parameter int N_CH      = 4,
    parameter int W         = 4,
    parameter int PRIO_MODE = 0
) (
    input  logic            clk,
    input  logic            rst_n,
    stream_mux_rr_if.slave  bus
);

    localparam int SW = chan_idx_w(N_CH);

    lock_state_e   state_reg,   state_next;
    logic [SW-1:0] lock_ch_reg, lock_ch_next;
    logic [SW-1:0] rr_ptr_reg,  rr_ptr_next;
    logic          valid_reg,   valid_next;
    logic [W-1:0]  data_reg,    data_next;
    logic          last_reg,    last_next;
    logic [SW-1:0] sel_reg,     sel_next;

    logic [SW-1:0] arb_grant;
    logic          arb_valid;
    logic [SW-1:0] cand;
    logic          cand_ok;
    logic          load_en;
    logic          accept;
    logic          cand_last;
    logic [SW-1:0] cand_succ;
    logic [W-1:0]  word [N_CH];

    rr_arbiter #(
        .N_CH      (N_CH),
        .PRIO_MODE (PRIO_MODE)
    ) u_arb (
        .req         (bus.in_valid),
        .ptr         (rr_ptr_reg),
        .grant       (arb_grant),
        .grant_valid (arb_valid)
    );

    genvar gi;
    generate
        for (gi = 0; gi < N_CH; gi++) begin : g_chan
            assign word[gi] = bus.in_data[gi*W +: W];
            // While locked the owner sees ready whenever the output can load,
            // even with valid low. Ready is withheld during reset so no
            // source believes a beat was taken that reset then discards.
            assign bus.in_ready[gi] = rst_n && load_en && cand_ok
                                      && (cand == SW'(gi));
        end
    endgenerate

    assign load_en   = !valid_reg || bus.out_ready;
    assign cand      = (state_reg == LOCK_HELD) ? lock_ch_reg : arb_grant;
    assign cand_ok   = (state_reg == LOCK_HELD) || arb_valid;
    assign accept    = load_en && cand_ok && bus.in_valid[cand];
    assign cand_last = bus.in_last[cand];
    // Explicit wrap compare: N_CH is not necessarily a power of two.
    assign cand_succ = (cand == SW'(N_CH - 1)) ? '0 : cand + 1'b1;

    always_comb begin
        state_next   = state_reg;
        lock_ch_next = lock_ch_reg;
        rr_ptr_next  = rr_ptr_reg;
        valid_next   = valid_reg;
        data_next    = data_reg;
        last_next    = last_reg;
        sel_next     = sel_reg;

        case (state_reg)
            LOCK_IDLE: begin
                if (accept && !cand_last) begin
                    state_next   = LOCK_HELD;
                    lock_ch_next = cand;
                end
            end
            LOCK_HELD: begin
                if (accept && cand_last) begin
                    state_next = LOCK_IDLE;
                end
            end
            default: state_next = LOCK_IDLE;
        endcase

        if (accept) begin
            valid_next = 1'b1;
            data_next  = word[cand];
            last_next  = cand_last;
            sel_next   = cand;
            if (cand_last) begin
                rr_ptr_next = cand_succ;
            end
        end else if (bus.out_ready) begin
            // Beat drained with nothing to replace it; payload fields hold.
            valid_next = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg   <= LOCK_IDLE;
            lock_ch_reg <= '0;
            rr_ptr_reg  <= '0;
            valid_reg   <= 1'b0;
            data_reg    <= '0;
            last_reg    <= 1'b0;
            sel_reg     <= '0;
        end else begin
            state_reg   <= state_next;
            lock_ch_reg <= lock_ch_next;
            rr_ptr_reg  <= rr_ptr_next;
            valid_reg   <= valid_next;
            data_reg    <= data_next;
            last_reg    <= last_next;
            sel_reg     <= sel_next;
        end
    end

    assign bus.out_valid = valid_reg;
    assign bus.out_data  = data_reg;
    assign bus.out_last  = last_reg;
    assign bus.out_sel   = sel_reg;

endmodule
